hmm_forward_ctrl: RTL and testbench



---
 rtl/hmm_forward_ctrl_pkg.sv | 31 +++
 rtl/hmm_forward_ctrl_if.sv | 13 +
 rtl/hmm_forward_ctrl_vec_mat_mult.sv | 24 ++
 rtl/hmm_forward_ctrl.sv | 112 +++++++++++
 tb/tb_hmm_forward_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hmm_forward_ctrl_pkg.sv
// rtl/hmm_forward_ctrl_pkg.sv - shared HMM sizes, types and fixed-point multiply
package hmm_forward_ctrl_pkg;

  localparam int HIDDEN_STATES = 2;
  localparam int OBS_SYMBOLS   = 2;
  localparam int DATA_PREC     = 16;
  localparam int FRAC_BITS     = 15;

  // one spare code so an out-of-range symbol is representable on the stream
  localparam int OBS_BITS = $clog2(OBS_SYMBOLS + 1);

  typedef enum logic [2:0] {
    HMM_IDLE = 3'd0,
    HMM_INIT = 3'd1,
    HMM_STEP = 3'd2,
    HMM_SUM  = 3'd3,
    HMM_DONE = 3'd4
  } hmm_fwd_state_t;

  typedef logic [HIDDEN_STATES-1:0][DATA_PREC-1:0] alpha_vec_t;
  typedef logic [HIDDEN_STATES-1:0][HIDDEN_STATES-1:0][DATA_PREC-1:0] trans_mat_t;
  typedef logic [HIDDEN_STATES-1:0][OBS_SYMBOLS-1:0][DATA_PREC-1:0] emit_mat_t;

  function automatic logic [DATA_PREC-1:0] multiply(input logic [DATA_PREC-1:0] a,
                                                    input logic [DATA_PREC-1:0] b);
    logic [2*DATA_PREC-1:0] p;
    p = {{DATA_PREC{1'b0}}, a} * {{DATA_PREC{1'b0}}, b};
    return DATA_PREC'(p >> FRAC_BITS);
  endfunction

endpackage

// File: rtl/hmm_forward_ctrl_if.sv
// rtl/hmm_forward_ctrl_if.sv - observation stream between source and forward controller
interface hmm_forward_ctrl_if;
  import hmm_forward_ctrl_pkg::*;

  logic                obs_valid;
  logic [OBS_BITS-1:0] obs_data;
  logic                obs_last;
  logic                obs_ready;

  modport master (output obs_valid, output obs_data, output obs_last, input obs_ready);
  modport slave  (input obs_valid, input obs_data, input obs_last, output obs_ready);

endinterface

// File: rtl/hmm_forward_ctrl_vec_mat_mult.sv
// rtl/hmm_forward_ctrl_vec_mat_mult.sv - row vector times matrix, wrap-around accumulation
module vec_mat_mult
  import hmm_forward_ctrl_pkg::*;
(
  input  alpha_vec_t vec,
  input  trans_mat_t mat,
  output alpha_vec_t prod
);

  logic [DATA_PREC-1:0] acc;

  always_comb begin
    prod = '0;
    acc  = '0;
    for (int j = 0; j < HIDDEN_STATES; j++) begin
      acc = '0;
      for (int i = 0; i < HIDDEN_STATES; i++) begin
        acc = acc + multiply(vec[i], mat[i][j]);
      end
      prod[j] = acc;
    end
  end

endmodule

// File: rtl/hmm_forward_ctrl.sv
// rtl/hmm_forward_ctrl.sv - HMM forward-pass sequencer; HMM_FWD_LIKELIHOOD_EN adds the SUM state
module hmm_forward_ctrl
  import hmm_forward_ctrl_pkg::*;
#(
  parameter int T_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  alpha_vec_t           pi,
  input  trans_mat_t           trans,
  input  emit_mat_t            emit,
  hmm_forward_ctrl_if.slave    obs,
  output alpha_vec_t           alpha,
  output logic [T_BITS-1:0]    t_count,
  output logic                 busy,
  output logic                 done,
  output logic                 sym_err,
  output logic [DATA_PREC-1:0] likelihood
);

  localparam logic [2:0] ST_IDLE = HMM_IDLE;
  localparam logic [2:0] ST_INIT = HMM_INIT;
  localparam logic [2:0] ST_STEP = HMM_STEP;
  localparam logic [2:0] ST_SUM  = HMM_SUM;
  localparam logic [2:0] ST_DONE = HMM_DONE;
`ifdef HMM_FWD_LIKELIHOOD_EN
  localparam logic [2:0] ST_FINAL = ST_SUM;
`else
  localparam logic [2:0] ST_FINAL = ST_DONE;
`endif
  localparam int SYM_IDX_BITS = (OBS_SYMBOLS > 1) ? $clog2(OBS_SYMBOLS) : 1;

  logic [2:0]              state;
  alpha_vec_t              mixed, ecol, init_alpha, step_alpha;
  logic                    sym_ok, hs;
  logic [SYM_IDX_BITS-1:0] sym_idx;

  assign obs.obs_ready = (state == ST_INIT) || (state == ST_STEP);
  assign busy          = obs.obs_ready || (state == ST_SUM);
  assign done          = (state == ST_DONE);
  assign hs            = obs.obs_valid && obs.obs_ready;
  assign sym_ok        = obs.obs_data < OBS_BITS'(OBS_SYMBOLS);
  assign sym_idx       = obs.obs_data[SYM_IDX_BITS-1:0];

  vec_mat_mult u_vec_mat_mult (
    .vec  (alpha),
    .mat  (trans),
    .prod (mixed)
  );

  // an out-of-range symbol selects an all-zero emission column
  always_comb begin
    ecol       = '0;
    init_alpha = '0;
    step_alpha = '0;
    for (int i = 0; i < HIDDEN_STATES; i++) begin
      if (sym_ok) ecol[i] = emit[i][sym_idx];
      init_alpha[i] = multiply(pi[i], ecol[i]);
      step_alpha[i] = multiply(mixed[i], ecol[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      alpha   <= '0;
      t_count <= '0;
      sym_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state   <= ST_INIT;
          t_count <= '0;
          sym_err <= 1'b0;
        end
        ST_INIT: if (hs) begin
          alpha   <= init_alpha;
          t_count <= T_BITS'(1);
          if (!sym_ok) sym_err <= 1'b1;
          state   <= obs.obs_last ? ST_FINAL : ST_STEP;
        end
        ST_STEP: if (hs) begin
          alpha <= step_alpha;
          if (t_count != '1) t_count <= t_count + T_BITS'(1);
          if (!sym_ok) sym_err <= 1'b1;
          if (obs.obs_last) state <= ST_FINAL;
        end
        ST_SUM:  state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef HMM_FWD_LIKELIHOOD_EN
  logic [DATA_PREC-1:0] alpha_sum;

  always_comb begin
    alpha_sum = '0;
    for (int i = 0; i < HIDDEN_STATES; i++) alpha_sum = alpha_sum + alpha[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  likelihood <= '0;
    else if (state == ST_SUM) likelihood <= alpha_sum;
  end
`else
  assign likelihood = '0;
`endif

endmodule

// File: tb/tb_hmm_forward_ctrl.sv
// tb/tb_hmm_forward_ctrl.sv - directed self-checking bench for hmm_forward_ctrl
module tb_hmm_forward_ctrl;
  import hmm_forward_ctrl_pkg::*;

  localparam int TB_T_BITS = 4;
`ifdef HMM_FWD_LIKELIHOOD_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  alpha_vec_t              pi, alpha;
  trans_mat_t              trans;
  emit_mat_t               emit;
  logic [TB_T_BITS-1:0]    t_count;
  logic                    busy, done, sym_err;
  logic [DATA_PREC-1:0]    likelihood;
  int                      checks = 0;
  int                      errors = 0;

  hmm_forward_ctrl_if obs_if ();

  hmm_forward_ctrl #(.T_BITS(TB_T_BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pi         (pi),
    .trans      (trans),
    .emit       (emit),
    .obs        (obs_if),
    .alpha      (alpha),
    .t_count    (t_count),
    .busy       (busy),
    .done       (done),
    .sym_err    (sym_err),
    .likelihood (likelihood)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_obs();
    obs_if.obs_valid = 1'b0;
    obs_if.obs_data  = '0;
    obs_if.obs_last  = 1'b0;
  endtask

  task automatic begin_seq(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_ready"}, {31'b0, obs_if.obs_ready}, 32'd1);
  endtask

  task automatic send(input int sym, input bit last);
    obs_if.obs_valid = 1'b1;
    obs_if.obs_data  = OBS_BITS'(sym);
    obs_if.obs_last  = last;
    step();
    idle_obs();
  endtask

  // called right after the clock that carried obs_last
  task automatic wait_done(input string tag);
    int lat;
    lat = 1;
    while (!done && lat < 10) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, LAT);
  endtask

  task automatic set_uniform();
    pi    = {2{16'h4000}};
    trans = {4{16'h4000}};
    emit  = {4{16'h4000}};
  endtask

  initial begin
    idle_obs();
    set_uniform();
    #12;
    check("rst_alpha", alpha, 32'h0);
    check("rst_tcount", t_count, 0);
    check("rst_flags", {busy, done, sym_err, obs_if.obs_ready}, 0);
    check("rst_lik", likelihood, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single observation
    begin_seq("t1");
    check("t1_busy", busy, 1);
    send(0, 1'b1);
    wait_done("t1");
    check("t1_alpha", alpha, {16'h2000, 16'h2000});
    check("t1_tcount", t_count, 1);
`ifdef HMM_FWD_LIKELIHOOD_EN
    check("t1_lik", likelihood, 16'h4000);
`endif
    step();
    check("t1_pulse", {done, busy}, 0);

    // three back-to-back observations
    begin
      int ready_cycles;
      int syms[3] = '{0, 1, 0};
      ready_cycles = 0;
      begin_seq("t2");
      for (int k = 0; k < 3; k++) begin
        if (obs_if.obs_ready) ready_cycles++;
        send(syms[k], k == 2);
      end
      wait_done("t2");
      check("t2_ready", ready_cycles, 3);
      check("t2_alpha", alpha, {16'h0800, 16'h0800});
      check("t2_tcount", t_count, 3);
      step();
    end

    // valid toggled off every other cycle
    begin
      int exp_t;
      int syms[3] = '{0, 1, 0};
      exp_t = 0;
      begin_seq("t3");
      for (int k = 0; k < 5; k++) begin
        if (k % 2 == 0) begin
          send(syms[k/2], k == 4);
          exp_t++;
        end else begin
          step();
        end
        check($sformatf("t3_tcount%0d", k), t_count, exp_t);
      end
      wait_done("t3");
      check("t3_alpha", alpha, {16'h0800, 16'h0800});
      step();
    end

    // out-of-range symbol
    begin_seq("t4");
    send(0, 1'b0);
    send(3, 1'b0);
    check("t4_alpha", alpha, 32'h0);
    check("t4_err", sym_err, 1);
    check("t4_tcount", t_count, 2);
    send(0, 1'b1);
    wait_done("t4");
    check("t4_alpha_end", alpha, 32'h0);
    step();
    check("t4_err_idle", sym_err, 1);
    begin_seq("t4b");
    check("t4_err_clr", sym_err, 0);
    send(0, 1'b1);
    wait_done("t4b");
    check("t4b_alpha", alpha, {16'h2000, 16'h2000});
    step();

    // asynchronous reset in STEP
    begin_seq("t5");
    send(0, 1'b0);
    send(1, 1'b0);
    rst = 1'b1;
    #1;
    check("t5_alpha", alpha, 32'h0);
    check("t5_tcount", t_count, 0);
    check("t5_flags", {busy, done, sym_err, obs_if.obs_ready}, 0);
    #1;
    rst = 1'b0;
    step();
    begin_seq("t5b");
    send(0, 1'b1);
    wait_done("t5b");
    check("t5b_alpha", alpha, {16'h2000, 16'h2000});
    check("t5b_tcount", t_count, 1);
    step();

    // start while busy is ignored
    begin_seq("t6");
    send(0, 1'b0);
    start = 1'b1;
    send(1, 1'b0);
    start = 1'b0;
    check("t6_tcount", t_count, 2);
    check("t6_alpha", alpha, {16'h1000, 16'h1000});
    send(0, 1'b1);
    wait_done("t6");
    check("t6_alpha_end", alpha, {16'h0800, 16'h0800});
    check("t6_tcount_end", t_count, 3);
    step();

    // asymmetric model: catches index order of trans/emit
    pi[0] = 16'h4000; pi[1] = 16'h2000;
    trans[0][0] = 16'h4000; trans[0][1] = 16'h4000;
    trans[1][0] = 16'h2000; trans[1][1] = 16'h6000;
    emit[0][0] = 16'h4000; emit[0][1] = 16'h2000;
    emit[1][0] = 16'h2000; emit[1][1] = 16'h6000;
    begin_seq("t7");
    send(0, 1'b0);
    check("t7_alpha_init", alpha, {16'h0800, 16'h2000});
    send(1, 1'b1);
    wait_done("t7");
    check("t7_alpha", alpha, {16'h1080, 16'h0480});
`ifdef HMM_FWD_LIKELIHOOD_EN
    check("t7_lik", likelihood, 16'h1500);
`endif
    step();

    // valid in IDLE is not consumed
    obs_if.obs_valid = 1'b1;
    step();
    step();
    check("t8_ready", obs_if.obs_ready, 0);
    check("t8_tcount", t_count, 2);
    idle_obs();

    // step counter saturates
    set_uniform();
    begin_seq("t9");
    for (int k = 0; k < 17; k++) send(0, k == 16);
    wait_done("t9");
    check("t9_tcount", t_count, 15);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
